// File: rtl/bram_arb_pkg.sv
// rtl/bram_arb_pkg.sv - shared encodings and default widths for the BRAM read-port arbiter
package bram_arb_pkg;

    // Debug-visible encoding; arb_state exports these values directly.
    typedef enum logic [1:0] {
        VGA_OWN = 2'd0,
        GUARD   = 2'd1,
        ARB     = 2'd2
    } arb_state_t;

    localparam int DEF_ADDR_W   = 17;
    localparam int DEF_DATA_W   = 12;
    localparam int DEF_BRAM_LAT = 2;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker
//
// Ports:
//   req   in  N      request vector
//   last  in  IDX_W  index granted last time; search starts just after it
//   gnt   out N      one-hot pick (zero when no request)
//   idx   out IDX_W  index of the pick (holds last when nothing picked)
//   valid out 1      some request was picked
module rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    // One spare bit so last+j (< 2N) never wraps before the modulo step.
    logic [IDX_W:0] k;

    always_comb begin
        gnt   = '0;
        idx   = last;
        valid = 1'b0;
        k     = '0;
        for (int j = 1; j <= N; j++) begin
            k = {1'b0, last} + (IDX_W + 1)'(j);
            if (k >= (IDX_W + 1)'(N)) begin
                k = k - (IDX_W + 1)'(N);
            end
            if (!valid && req[k[IDX_W-1:0]]) begin
                valid              = 1'b1;
                gnt[k[IDX_W-1:0]]  = 1'b1;
                idx                = k[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// rtl/bram_port_arbiter.sv - shares the image BRAM read port between VGA and N_REQ secondary readers
//
// Ports:
//   clk, rst_n        pixel clock, asynchronous active-low reset
//   vga_busy          pixel pipeline needs the port (VGA owns it with zero latency)
//   vga_addr          VGA pixel address
//   req, req_addr     per-requester level request and address slice [i*ADDR_W +: ADDR_W]
//   gnt               one-cycle grant; the requester address is captured in this cycle
//   rvalid, rdata     read return pulse per requester, shared data (held between returns)
//   bram_addr         BRAM read address
//   bram_rdata        BRAM read data, BRAM_LAT cycles after the address
//   starve, starve_clr sticky starvation flags and their clear
//   arb_state         current FSM state (VGA_OWN=0, GUARD=1, ARB=2)
// Optional (ARB_STATS_EN): grant_cnt (16 bits per requester), vga_preempt.
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int N_REQ      = 2,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int BRAM_LAT   = DEF_BRAM_LAT,
    parameter int GUARD_CYC  = 3,
    parameter int STARVE_LIM = 1023
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    vga_busy,
    input  logic [ADDR_W-1:0]       vga_addr,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]       rdata,
    output logic [ADDR_W-1:0]       bram_addr,
    input  logic [DATA_W-1:0]       bram_rdata,
    output logic [N_REQ-1:0]        starve,
    input  logic                    starve_clr,
    output logic [1:0]              arb_state
`ifdef ARB_STATS_EN
    ,
    output logic [N_REQ*16-1:0]     grant_cnt,
    output logic [15:0]             vga_preempt
`endif
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int GC_W  = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;
    localparam int SC_W  = $clog2(STARVE_LIM + 1);
    localparam logic [GC_W-1:0]  GUARD_LOAD = GC_W'(GUARD_CYC - 1);
    localparam logic [SC_W-1:0]  WAIT_MAX   = SC_W'(STARVE_LIM);
    localparam logic [IDX_W-1:0] PTR_INIT   = IDX_W'(N_REQ - 1);

    arb_state_t                   state_q, state_d;
    logic [GC_W-1:0]              guard_q, guard_d;
    logic                         arb_en;
    logic [IDX_W-1:0]             ptr_q;
    logic [IDX_W-1:0]             pick_idx;
    logic [N_REQ-1:0]             pick_gnt;
    logic                         pick_valid;
    logic                         grant_any;
    logic [ADDR_W-1:0]            addr_q, pick_addr;
    logic [BRAM_LAT:0][N_REQ-1:0] tag_q;
    logic [DATA_W-1:0]            rdata_q;
    logic [SC_W-1:0]              wait_q [N_REQ];
    logic [SC_W-1:0]              wait_d [N_REQ];
    logic [N_REQ-1:0]             starve_q;

    rr_pick #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (req),
        .last  (ptr_q),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // Next-state logic. arb_en is only raised in ARB with VGA idle, so a
    // same-cycle vga_busy always beats a pending request.
    always_comb begin
        state_d = state_q;
        guard_d = guard_q;
        arb_en  = 1'b0;
        case (state_q)
            VGA_OWN: begin
                if (!vga_busy) begin
                    state_d = GUARD;
                    guard_d = GUARD_LOAD;
                end
            end
            GUARD: begin
                if (vga_busy) begin
                    state_d = VGA_OWN;
                end else if (guard_q == '0) begin
                    state_d = ARB;
                end else begin
                    guard_d = guard_q - GC_W'(1);
                end
            end
            ARB: begin
                if (vga_busy) begin
                    state_d = VGA_OWN;
                end else begin
                    arb_en = 1'b1;
                end
            end
            default: state_d = ARB;
        endcase
    end

    assign grant_any = arb_en && pick_valid;
    assign gnt       = arb_en ? pick_gnt : '0;

    always_comb begin
        pick_addr = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_gnt[i]) begin
                pick_addr = req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // VGA path is a pure mux: no register between vga_addr and the BRAM.
    assign bram_addr = (state_q == VGA_OWN) ? vga_addr : addr_q;
    assign arb_state = state_q;

    // Tag stage 0 lines up with the address cycle, stage BRAM_LAT with the data.
    assign rvalid = tag_q[BRAM_LAT];
    assign rdata  = (|rvalid) ? bram_rdata : rdata_q;
    assign starve = starve_q;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            wait_d[i] = '0;
            if (req[i] && !gnt[i]) begin
                wait_d[i] = (wait_q[i] == WAIT_MAX) ? WAIT_MAX : wait_q[i] + SC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ARB;
            guard_q  <= '0;
            ptr_q    <= PTR_INIT;
            addr_q   <= '0;
            tag_q    <= '0;
            rdata_q  <= '0;
            starve_q <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                wait_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            guard_q <= guard_d;
            if (grant_any) begin
                addr_q <= pick_addr;
                ptr_q  <= pick_idx;
            end
            tag_q <= {tag_q[BRAM_LAT-1:0], gnt};
            if (|rvalid) begin
                rdata_q <= bram_rdata;
            end
            for (int i = 0; i < N_REQ; i++) begin
                wait_q[i] <= wait_d[i];
                // Clear beats a same-cycle set.
                if (starve_clr) begin
                    starve_q[i] <= 1'b0;
                end else if (wait_d[i] == WAIT_MAX) begin
                    starve_q[i] <= 1'b1;
                end
            end
        end
    end

`ifdef ARB_STATS_EN
    logic [15:0] gcnt_q [N_REQ];
    logic [15:0] preempt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            preempt_q <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                gcnt_q[i] <= '0;
            end
        end else if (starve_clr) begin
            preempt_q <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                gcnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (gnt[i] && gcnt_q[i] != 16'hFFFF) begin
                    gcnt_q[i] <= gcnt_q[i] + 16'd1;
                end
            end
            if (state_q == ARB && vga_busy && (|req) && preempt_q != 16'hFFFF) begin
                preempt_q <= preempt_q + 16'd1;
            end
        end
    end

    for (genvar g = 0; g < N_REQ; g++) begin : g_gcnt
        assign grant_cnt[g*16 +: 16] = gcnt_q[g];
    end
    assign vga_preempt = preempt_q;
`endif

endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb/tb_bram_port_arbiter.sv - randomized self-checking bench for bram_port_arbiter
module tb_bram_port_arbiter;

    localparam int NR    = 2;
    localparam int AW    = 17;
    localparam int DW    = 12;
    localparam int LAT   = 2;
    localparam int GCYC  = 3;
    localparam int SLIM  = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             vga_busy = 1'b0;
    logic [AW-1:0]    vga_addr = '0;
    logic [NR-1:0]    req = '0;
    logic [NR*AW-1:0] req_addr = '0;
    logic [NR-1:0]    gnt;
    logic [NR-1:0]    rvalid;
    logic [DW-1:0]    rdata;
    logic [AW-1:0]    bram_addr;
    logic [DW-1:0]    bram_rdata = '0;
    logic [NR-1:0]    starve;
    logic             starve_clr = 1'b0;
    logic [1:0]       arb_state;

    bram_port_arbiter #(
        .N_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .BRAM_LAT(LAT),
        .GUARD_CYC(GCYC), .STARVE_LIM(SLIM)
    ) dut (
        .clk(clk), .rst_n(rst_n), .vga_busy(vga_busy), .vga_addr(vga_addr),
        .req(req), .req_addr(req_addr), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .bram_addr(bram_addr), .bram_rdata(bram_rdata), .starve(starve),
        .starve_clr(starve_clr), .arb_state(arb_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model state
    typedef struct {
        int          k;
        int          due;
        logic [AW-1:0] addr;
    } rd_t;
    rd_t           rq[$];
    int            low_run;
    int            ptr;
    logic [AW-1:0] m_addr_q;
    logic [DW-1:0] m_rdata;
    int            wcnt [NR];
    logic [NR-1:0] m_starve;
    logic [AW-1:0] ah1, ah2;

    logic [NR-1:0] exp_gnt, exp_rvalid, exp_starve;
    logic [DW-1:0] exp_rdata;
    logic [AW-1:0] exp_baddr;
    logic [1:0]    exp_state;
    int            gk;

    function automatic logic [DW-1:0] mem(input logic [AW-1:0] a);
        logic [AW-1:0] t;
        t = a ^ (a >> 5) ^ 17'h0A5A5;
        return t[DW-1:0];
    endfunction

    task automatic model_reset();
        rq.delete();
        low_run  = 1000;
        ptr      = NR - 1;
        m_addr_q = '0;
        m_rdata  = '0;
        m_starve = '0;
        for (int i = 0; i < NR; i++) wcnt[i] = 0;
    endtask

    // Expected outputs for the current cycle from the rules: VGA owns the port
    // right after any busy cycle, GUARD covers the next GCYC idle cycles, then ARB.
    task automatic model_eval();
        if (low_run == 0)         exp_state = 2'd0;
        else if (low_run <= GCYC) exp_state = 2'd1;
        else                      exp_state = 2'd2;
        exp_baddr = (exp_state == 2'd0) ? vga_addr : m_addr_q;
        exp_gnt = '0;
        gk = -1;
        if (exp_state == 2'd2 && !vga_busy) begin
            for (int j = 1; j <= NR; j++) begin
                if (gk < 0 && req[(ptr + j) % NR]) gk = (ptr + j) % NR;
            end
        end
        if (gk >= 0) exp_gnt[gk] = 1'b1;
        exp_rvalid = '0;
        exp_rdata  = m_rdata;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            exp_rvalid[rq[0].k] = 1'b1;
            exp_rdata = mem(rq[0].addr);
        end
        exp_starve = m_starve;
    endtask

    task automatic model_commit();
        if (gk >= 0) begin
            m_addr_q = req_addr[gk*AW +: AW];
            rq.push_back('{gk, cyc + 1 + LAT, m_addr_q});
            ptr = gk;
        end
        if (exp_rvalid != '0) begin
            m_rdata = exp_rdata;
            void'(rq.pop_front());
        end
        for (int i = 0; i < NR; i++) begin
            if (req[i] && !exp_gnt[i]) wcnt[i] = (wcnt[i] < SLIM) ? wcnt[i] + 1 : SLIM;
            else wcnt[i] = 0;
            if (starve_clr) m_starve[i] = 1'b0;
            else if (wcnt[i] == SLIM) m_starve[i] = 1'b1;
        end
        low_run = vga_busy ? 0 : ((low_run < 1000) ? low_run + 1 : 1000);
        ah2 = ah1;
        ah1 = bram_addr;
    endtask

    task automatic settle();
        @(negedge clk);
        model_eval();
    endtask

    // BRAM stand-in: data this cycle belongs to the address LAT cycles ago.
    task automatic advance();
        model_commit();
        @(posedge clk);
        #1;
        cyc++;
        bram_rdata = mem(ah2);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        vga_busy = 1'b0;
        req = '0;
        starve_clr = 1'b0;
        ah1 = '0;
        ah2 = '0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if ({gnt, rvalid, rdata, bram_addr, starve, arb_state} !== {2'b0, 2'b0, 12'h0, 17'h0, 2'b0, 2'd2}) begin
            errors++;
            $display("FAIL reset_init gnt=%b rvalid=%b rdata=%h addr=%h starve=%b state=%0d, want all 0 and state 2",
                     gnt, rvalid, rdata, bram_addr, starve, arb_state);
        end
        model_reset();
        @(posedge clk);
        #1;
        cyc++;
        rst_n = 1'b1;
    endtask

    task automatic test_round_robin();
        int seq [4];
        seq = '{0, 1, 0, 1};
        vga_busy = 1'b0;
        req_addr = {17'h0AAAA, 17'h05555};
        for (int i = 0; i < 4; i++) begin
            req = 2'b11;
            settle();
            checks++;
            if ({gnt, rvalid, rdata, bram_addr, starve, arb_state} !== {exp_gnt, exp_rvalid, exp_rdata, exp_baddr, exp_starve, exp_state}) begin
                errors++;
                $display("FAIL rr_model cyc=%0d gnt=%b/%b rvalid=%b/%b rdata=%h/%h addr=%h/%h starve=%b/%b state=%0d/%0d",
                         cyc, gnt, exp_gnt, rvalid, exp_rvalid, rdata, exp_rdata, bram_addr, exp_baddr, starve, exp_starve, arb_state, exp_state);
            end
            checks++;
            if (gnt !== (2'b01 << seq[i])) begin
                errors++;
                $display("FAIL rr_order step=%0d gnt=%b want=%b", i, gnt, 2'b01 << seq[i]);
            end
            advance();
        end
        req = '0;
        for (int i = 0; i < 4; i++) begin
            settle();
            checks++;
            if ({gnt, rvalid, rdata, bram_addr, starve, arb_state} !== {exp_gnt, exp_rvalid, exp_rdata, exp_baddr, exp_starve, exp_state}) begin
                errors++;
                $display("FAIL rr_drain cyc=%0d rvalid=%b/%b rdata=%h/%h", cyc, rvalid, exp_rvalid, rdata, exp_rdata);
            end
            advance();
        end
    endtask

    task automatic test_vga_pass();
        logic [AW-1:0] addrs [4];
        addrs = '{17'h1ABCD, 17'h1ABCD, 17'h00F0F, 17'h1FFFF};
        vga_busy = 1'b1;
        req = 2'b01;
        req_addr = {17'h0, 17'h00123};
        for (int i = 0; i < 4; i++) begin
            vga_addr = addrs[i];
            settle();
            checks++;
            if ({gnt, rvalid, rdata, bram_addr, starve, arb_state} !== {exp_gnt, exp_rvalid, exp_rdata, exp_baddr, exp_starve, exp_state}) begin
                errors++;
                $display("FAIL vga_model cyc=%0d gnt=%b/%b addr=%h/%h state=%0d/%0d",
                         cyc, gnt, exp_gnt, bram_addr, exp_baddr, arb_state, exp_state);
            end
            if (i > 0) begin
                checks++;
                if (bram_addr !== addrs[i] || gnt !== 2'b00) begin
                    errors++;
                    $display("FAIL vga_pass step=%0d bram_addr=%h gnt=%b want addr=%h gnt=00", i, bram_addr, gnt, addrs[i]);
                end
            end
            advance();
        end
    endtask

    task automatic test_guard_grant();
        int g_at, rv_at;
        logic held;
        g_at = -1;
        rv_at = -1;
        held = 1'b1;
        vga_busy = 1'b1;
        req = '0;
        settle();
        advance();
        req_addr = {17'h0, 17'h00400};
        for (int i = 0; i < 12; i++) begin
            vga_busy = 1'b0;
            req = {1'b0, held};
            settle();
            checks++;
            if ({gnt, rvalid, rdata, bram_addr, starve, arb_state} !== {exp_gnt, exp_rvalid, exp_rdata, exp_baddr, exp_starve, exp_state}) begin
                errors++;
                $display("FAIL guard_model cyc=%0d gnt=%b/%b rvalid=%b/%b addr=%h/%h state=%0d/%0d",
                         cyc, gnt, exp_gnt, rvalid, exp_rvalid, bram_addr, exp_baddr, arb_state, exp_state);
            end
            if (gnt[0] && g_at < 0) g_at = i;
            if (i == 5) begin
                checks++;
                if (bram_addr !== 17'h00400) begin
                    errors++;
                    $display("FAIL guard_addr bram_addr=%h want=00400", bram_addr);
                end
            end
            if (rvalid[0] && rv_at < 0) begin
                rv_at = i;
                checks++;
                if (rdata !== bram_rdata) begin
                    errors++;
                    $display("FAIL guard_rdata rdata=%h want=%h", rdata, bram_rdata);
                end
            end
            if (gnt[0]) held = 1'b0;
            advance();
        end
        checks++;
        if (g_at != 4 || rv_at != 7) begin
            errors++;
            $display("FAIL guard_timing gnt_at=%0d rvalid_at=%0d want 4 and 7", g_at, rv_at);
        end
    endtask

    task automatic test_tie_preempt();
        int rv_cnt;
        rv_cnt = 0;
        req_addr = {17'h01111, 17'h02222};
        for (int i = 0; i < 13; i++) begin
            vga_busy = (i >= 7);
            req = (i < 5) ? 2'b00 : (i < 7) ? 2'b01 : 2'b10;
            settle();
            checks++;
            if ({gnt, rvalid, rdata, bram_addr, starve, arb_state} !== {exp_gnt, exp_rvalid, exp_rdata, exp_baddr, exp_starve, exp_state}) begin
                errors++;
                $display("FAIL tie_model cyc=%0d gnt=%b/%b rvalid=%b/%b rdata=%h/%h state=%0d/%0d",
                         cyc, gnt, exp_gnt, rvalid, exp_rvalid, rdata, exp_rdata, arb_state, exp_state);
            end
            if (i == 7) begin
                checks++;
                if (gnt !== 2'b00 || arb_state !== 2'd2) begin
                    errors++;
                    $display("FAIL tie_nogrant gnt=%b state=%0d want gnt=00 state=2", gnt, arb_state);
                end
            end
            if (i == 8) begin
                checks++;
                if (arb_state !== 2'd0) begin
                    errors++;
                    $display("FAIL tie_state state=%0d want=0", arb_state);
                end
            end
            if (i >= 7 && rvalid[0]) rv_cnt++;
            advance();
        end
        checks++;
        if (rv_cnt != 2) begin
            errors++;
            $display("FAIL tie_inflight rvalid_count=%0d want=2", rv_cnt);
        end
    endtask

    task automatic test_starvation();
        int set_at;
        set_at = -1;
        vga_busy = 1'b1;
        req = '0;
        starve_clr = 1'b1;
        settle();
        advance();
        starve_clr = 1'b0;
        for (int i = 0; i < 13; i++) begin
            req = (i < 12) ? 2'b10 : 2'b00;
            starve_clr = (i == 11);
            settle();
            checks++;
            if ({gnt, rvalid, rdata, bram_addr, starve, arb_state} !== {exp_gnt, exp_rvalid, exp_rdata, exp_baddr, exp_starve, exp_state}) begin
                errors++;
                $display("FAIL starve_model cyc=%0d starve=%b/%b gnt=%b/%b", cyc, starve, exp_starve, gnt, exp_gnt);
            end
            if (starve[1] && set_at < 0) set_at = i;
            if (i == 12) begin
                checks++;
                if (starve !== 2'b00) begin
                    errors++;
                    $display("FAIL starve_clear starve=%b want=00", starve);
                end
            end
            advance();
        end
        starve_clr = 1'b0;
        checks++;
        if (set_at != 8) begin
            errors++;
            $display("FAIL starve_time set_at=%0d want=8", set_at);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(7) == 0) vga_busy = ~vga_busy;
            vga_addr   = AW'($urandom);
            req        = NR'($urandom);
            req_addr   = {2'($urandom), 32'($urandom)};
            starve_clr = ($urandom_range(39) == 0);
            settle();
            checks++;
            if ({gnt, rvalid, rdata, bram_addr, starve, arb_state} !== {exp_gnt, exp_rvalid, exp_rdata, exp_baddr, exp_starve, exp_state}) begin
                errors++;
                $display("FAIL rand_model cyc=%0d gnt=%b/%b rvalid=%b/%b rdata=%h/%h addr=%h/%h starve=%b/%b state=%0d/%0d",
                         cyc, gnt, exp_gnt, rvalid, exp_rvalid, rdata, exp_rdata, bram_addr, exp_baddr, starve, exp_starve, arb_state, exp_state);
            end
            advance();
        end
        starve_clr = 1'b0;
    endtask

    task automatic test_reset_midstream();
        int rv_cnt;
        rv_cnt = 0;
        vga_busy = 1'b0;
        req_addr = {17'h03333, 17'h04444};
        for (int i = 0; i < 7; i++) begin
            req = (i < 5) ? 2'b00 : 2'b11;
            settle();
            advance();
        end
        test_reset();
        for (int i = 0; i < 6; i++) begin
            req = '0;
            settle();
            checks++;
            if ({gnt, rvalid, rdata, bram_addr, starve, arb_state} !== {exp_gnt, exp_rvalid, exp_rdata, exp_baddr, exp_starve, exp_state}) begin
                errors++;
                $display("FAIL reset_flush_model cyc=%0d rvalid=%b/%b rdata=%h/%h", cyc, rvalid, exp_rvalid, rdata, exp_rdata);
            end
            if (rvalid != '0) rv_cnt++;
            advance();
        end
        checks++;
        if (rv_cnt != 0) begin
            errors++;
            $display("FAIL reset_flush rvalid_after_reset=%0d want=0", rv_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_vga_pass();
        test_guard_grant();
        test_tie_preempt();
        test_starvation();
        test_random();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
